// File: rtl/risc_pkg.sv
// Shared definitions for the RISC_FSM datapath: opcodes, FSM states,
// instruction field positions and default widths.
package risc_pkg;

  localparam int DATA_W_DEFAULT   = 8;
  localparam int NUM_REGS_DEFAULT = 4;
  localparam int REG_AW           = 2;
  localparam int INSTR_W          = 16;

  // Opcodes; 110 and 111 are undefined and raise illegal.
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_LDI = 3'b101;

  // Instruction field positions.
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;
  localparam int RD_MSB  = 12;
  localparam int RD_LSB  = 11;
  localparam int RS1_MSB = 10;
  localparam int RS1_LSB = 9;
  localparam int RS2_MSB = 8;
  localparam int RS2_LSB = 7;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DECODE    = 2'd1,
    ST_EXECUTE   = 2'd2,
    ST_WRITEBACK = 2'd3
  } state_t;

  // Opcodes above LDI are undefined.
  function automatic logic is_legal(input logic [2:0] op);
    return (op <= OP_LDI);
  endfunction

endpackage

// File: rtl/reg_file_4x8.sv
// Small register file: two asynchronous read ports, one synchronous write
// port, asynchronous active-low reset of every entry to zero.
module reg_file_4x8 #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int AW       = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_W-1:0] q;

      // Each entry loads wdata when addressed by an enabled write.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q <= '0;
        end else if (we && (waddr == AW'(gi))) begin
          q <= wdata;
        end
      end

      assign regs[gi] = q;
    end
  endgenerate

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer in front of the 8-bit combinational ALU.
// IDLE -> DECODE -> EXECUTE -> WRITEBACK; one instruction per 4 cycles.
// Optional feature macro: ALU_SEQ_FLAGS_EN adds zero_flag / neg_flag outputs.
module alu_sequencer
  import risc_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int NUM_REGS = NUM_REGS_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  output logic [2:0]         alu_control,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  input  logic [DATA_W-1:0]  alu_result,
  output logic               wb_valid,
  output logic [REG_AW-1:0]  wb_addr,
  output logic [DATA_W-1:0]  wb_data,
  output logic               illegal
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic               zero_flag,
  output logic               neg_flag
`endif
);

  state_t state, state_next;

  logic [INSTR_W-1:0] instr_latch, instr_latch_next;
  logic [DATA_W-1:0]  result, result_next;
  logic               instr_ready_next;
  logic [2:0]         alu_control_next;
  logic [DATA_W-1:0]  alu_a_next, alu_b_next;
  logic               wb_valid_next;
  logic [REG_AW-1:0]  wb_addr_next;
  logic [DATA_W-1:0]  wb_data_next;
  logic               illegal_next;
  logic               rf_we;

  logic [2:0]         opcode;
  logic [REG_AW-1:0]  rd, rs1, rs2;
  logic [7:0]         imm;
  logic [DATA_W-1:0]  rs1_data, rs2_data;

  assign opcode = instr_latch[OPC_MSB:OPC_LSB];
  assign rd     = instr_latch[RD_MSB:RD_LSB];
  assign rs1    = instr_latch[RS1_MSB:RS1_LSB];
  assign rs2    = instr_latch[RS2_MSB:RS2_LSB];
  assign imm    = instr_latch[IMM_MSB:IMM_LSB];

  reg_file_4x8 #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .AW       (REG_AW)
  ) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (rd),
    .wdata   (result),
    .raddr_a (rs1),
    .rdata_a (rs1_data),
    .raddr_b (rs2),
    .rdata_b (rs2_data)
  );

  // Next-state and next-output logic; outputs not touched hold their value.
  always_comb begin
    state_next       = state;
    instr_latch_next = instr_latch;
    result_next      = result;
    alu_control_next = alu_control;
    alu_a_next       = alu_a;
    alu_b_next       = alu_b;
    wb_valid_next    = 1'b0;
    wb_addr_next     = wb_addr;
    wb_data_next     = wb_data;
    illegal_next     = 1'b0;
    rf_we            = 1'b0;

    case (state)
      ST_IDLE: begin
        if (instr_valid && instr_ready) begin
          instr_latch_next = instr;
          state_next       = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (!is_legal(opcode)) begin
          illegal_next = 1'b1;
          state_next   = ST_IDLE;
        end else begin
          state_next = ST_EXECUTE;
          if (opcode == OP_LDI) begin
            // LDI passes the immediate through the ALU as imm + 0.
            alu_control_next = OP_ADD;
            alu_a_next       = DATA_W'(imm);
            alu_b_next       = '0;
          end else begin
            alu_control_next = opcode;
            alu_a_next       = rs1_data;
            alu_b_next       = (opcode == OP_NOT) ? '0 : rs2_data;
          end
        end
      end
      ST_EXECUTE: begin
        result_next = alu_result;
        state_next  = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        rf_we         = 1'b1;
        wb_valid_next = 1'b1;
        wb_addr_next  = rd;
        wb_data_next  = result;
        state_next    = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // Ready is registered: high exactly while the FSM sits in IDLE.
    instr_ready_next = (state_next == ST_IDLE);
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      instr_latch <= '0;
      result      <= '0;
      instr_ready <= 1'b0;
      alu_control <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      wb_valid    <= 1'b0;
      wb_addr     <= '0;
      wb_data     <= '0;
      illegal     <= 1'b0;
    end else begin
      state       <= state_next;
      instr_latch <= instr_latch_next;
      result      <= result_next;
      instr_ready <= instr_ready_next;
      alu_control <= alu_control_next;
      alu_a       <= alu_a_next;
      alu_b       <= alu_b_next;
      wb_valid    <= wb_valid_next;
      wb_addr     <= wb_addr_next;
      wb_data     <= wb_data_next;
      illegal     <= illegal_next;
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  // Status flags follow each write-back and hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_flag <= 1'b0;
      neg_flag  <= 1'b0;
    end else if (state == ST_WRITEBACK) begin
      zero_flag <= (result == '0);
      neg_flag  <= result[DATA_W-1];
    end
  end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed, table-driven bench for alu_sequencer with a behavioural ALU.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_ready;
  logic [2:0]  alu_control;
  logic [7:0]  alu_a, alu_b, alu_result;
  logic        wb_valid;
  logic [1:0]  wb_addr;
  logic [7:0]  wb_data;
  logic        illegal;
`ifdef ALU_SEQ_FLAGS_EN
  logic        zero_flag, neg_flag;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .alu_control (alu_control),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .illegal     (illegal)
`ifdef ALU_SEQ_FLAGS_EN
    ,
    .zero_flag   (zero_flag),
    .neg_flag    (neg_flag)
`endif
  );

  // The downstream combinational ALU.
  always_comb begin
    case (alu_control)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b100:  alu_result = ~alu_a;
      default: alu_result = 8'h00;
    endcase
  end

  typedef struct {
    logic [15:0] instr;
    logic        ill;
    logic [2:0]  ctrl;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [1:0]  wa;
    logic [7:0]  wd;
    logic        z;
    logic        n;
  } vec_t;

  vec_t tbl [16];

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs1, input logic [1:0] rs2);
    return {op, rd, rs1, rs2, 7'h00};
  endfunction

  function automatic logic [15:0] ldi(input logic [1:0] rd, input logic [7:0] imm);
    return {3'b101, rd, 3'b000, imm};
  endfunction

  function automatic vec_t mk(input logic [15:0] i, input logic ill, input logic [2:0] c,
                              input logic [7:0] a, input logic [7:0] b, input logic [1:0] wa,
                              input logic [7:0] wd, input logic z, input logic n);
    vec_t v;
    v.instr = i; v.ill = ill; v.ctrl = c; v.a = a; v.b = b;
    v.wa = wa; v.wd = wd; v.z = z; v.n = n;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Wait (bounded) for ready at a negedge; returns 1 if ready seen.
  task automatic wait_ready(output bit ok);
    int waited = 0;
    while (!instr_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    ok = instr_ready;
    if (!ok) check("ready_timeout", {31'b0, instr_ready}, 32'd1);
  endtask

  // Issue one instruction and check it cycle by cycle; starts and ends at a negedge.
  task automatic run_vec(input int idx, input vec_t v);
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    instr_valid = 1'b1;
    instr       = v.instr;
    @(negedge clk);                       // acceptance edge passed: DECODE
    instr_valid = 1'b0;
    instr       = 16'($urandom);
    check("ready_drop", {31'b0, instr_ready}, 32'd0);
    @(negedge clk);                       // one cycle after acceptance
    if (v.ill) begin
      check("illegal_pulse", {31'b0, illegal}, 32'd1);
      check("ill_no_wb", {31'b0, wb_valid}, 32'd0);
      check("ill_ready_back", {31'b0, instr_ready}, 32'd1);
      @(negedge clk);
      check("illegal_one_cycle", {31'b0, illegal}, 32'd0);
      check("ill_no_wb_late", {31'b0, wb_valid}, 32'd0);
`ifdef ALU_SEQ_FLAGS_EN
      check("ill_zero_hold", {31'b0, zero_flag}, {31'b0, v.z});
      check("ill_neg_hold", {31'b0, neg_flag}, {31'b0, v.n});
`endif
      $display("vec %0d instr=%04h illegal=%0b", idx, v.instr, illegal);
      return;
    end
    check("no_illegal", {31'b0, illegal}, 32'd0);
    check("alu_control", {29'b0, alu_control}, {29'b0, v.ctrl});
    check("alu_a", {24'b0, alu_a}, {24'b0, v.a});
    check("alu_b", {24'b0, alu_b}, {24'b0, v.b});
    @(negedge clk);                       // WRITEBACK cycle
    check("wb_early", {31'b0, wb_valid}, 32'd0);
    @(negedge clk);                       // 3 cycles after acceptance
    check("wb_valid", {31'b0, wb_valid}, 32'd1);
    check("wb_addr", {30'b0, wb_addr}, {30'b0, v.wa});
    check("wb_data", {24'b0, wb_data}, {24'b0, v.wd});
    check("ready_idle", {31'b0, instr_ready}, 32'd1);
    check("alu_a_hold", {24'b0, alu_a}, {24'b0, v.a});
`ifdef ALU_SEQ_FLAGS_EN
    check("zero_flag", {31'b0, zero_flag}, {31'b0, v.z});
    check("neg_flag", {31'b0, neg_flag}, {31'b0, v.n});
`endif
    $display("vec %0d instr=%04h wb R%0d=%02h", idx, v.instr, wb_addr, wb_data);
    @(negedge clk);
    check("wb_one_cycle", {31'b0, wb_valid}, 32'd0);
  endtask

  initial begin
    int acc [$];
    int last;
    bit ok;

    //           instr                      ill ctrl  a      b      wa  wd     z  n
    tbl[0]  = mk(ldi(2'd1, 8'h05),          0, 3'd0, 8'h05, 8'h00, 1, 8'h05, 0, 0);
    tbl[1]  = mk(ldi(2'd2, 8'h03),          0, 3'd0, 8'h03, 8'h00, 2, 8'h03, 0, 0);
    tbl[2]  = mk(enc(3'b000, 3, 1, 2),      0, 3'd0, 8'h05, 8'h03, 3, 8'h08, 0, 0);
    tbl[3]  = mk(ldi(2'd0, 8'h00),          0, 3'd0, 8'h00, 8'h00, 0, 8'h00, 1, 0);
    tbl[4]  = mk(enc(3'b001, 0, 0, 1),      0, 3'd1, 8'h00, 8'h05, 0, 8'hFB, 0, 1);
    tbl[5]  = mk(ldi(2'd2, 8'h0F),          0, 3'd0, 8'h0F, 8'h00, 2, 8'h0F, 0, 0);
    tbl[6]  = mk(enc(3'b100, 2, 2, 1),      0, 3'd4, 8'h0F, 8'h00, 2, 8'hF0, 0, 1);
    tbl[7]  = mk(enc(3'b010, 3, 1, 1),      0, 3'd2, 8'h05, 8'h05, 3, 8'h05, 0, 0);
    tbl[8]  = mk(enc(3'b011, 1, 2, 3),      0, 3'd3, 8'hF0, 8'h05, 1, 8'hF5, 0, 1);
    tbl[9]  = mk({3'b110, 2'd1, 11'h5A5},   1, 3'd0, 8'h00, 8'h00, 0, 8'h00, 0, 1);
    tbl[10] = mk(enc(3'b011, 0, 0, 1),      0, 3'd3, 8'hFB, 8'hF5, 0, 8'hFF, 0, 1);
    tbl[11] = mk(enc(3'b000, 2, 2, 2),      0, 3'd0, 8'hF0, 8'hF0, 2, 8'hE0, 0, 1);
    tbl[12] = mk({3'b111, 2'd3, 11'h7FF},   1, 3'd0, 8'h00, 8'h00, 0, 8'h00, 0, 1);
    tbl[13] = mk(enc(3'b001, 3, 3, 1),      0, 3'd1, 8'h05, 8'hF5, 3, 8'h10, 0, 0);
    tbl[14] = mk(ldi(2'd1, 8'h80),          0, 3'd0, 8'h80, 8'h00, 1, 8'h80, 0, 1);
    tbl[15] = mk(enc(3'b001, 1, 1, 1),      0, 3'd1, 8'h80, 8'h80, 1, 8'h00, 1, 0);

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, instr_ready}, 32'd0);
    check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("rst_illegal", {31'b0, illegal}, 32'd0);
    check("rst_alu", {13'b0, alu_control, alu_a, alu_b}, 32'd0);
    check("rst_wb", {22'b0, wb_addr, wb_data}, 32'd0);
`ifdef ALU_SEQ_FLAGS_EN
    check("rst_flags", {30'b0, zero_flag, neg_flag}, 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {31'b0, instr_ready}, 32'd1);

    for (int i = 0; i < 16; i++) run_vec(i, tbl[i]);

    // instr_valid held high: one acceptance every 4 cycles.
    wait_ready(ok);
    instr_valid = 1'b1;
    instr       = ldi(2'd0, 8'h11);
    for (int c = 0; c < 16; c++) begin
      if (instr_valid && instr_ready) acc.push_back(c);
      @(negedge clk);
    end
    instr_valid = 1'b0;
    check("throughput_count", acc.size(), 32'd4);
    last = -4;
    foreach (acc[k]) begin
      check("throughput_gap", acc[k] - last, 32'd4);
      last = acc[k];
    end
    $display("throughput: %0d acceptances in 16 cycles", acc.size());
    wait_ready(ok);

    // Reset pulsed during EXECUTE aborts the instruction.
    instr_valid = 1'b1;
    instr       = ldi(2'd1, 8'h77);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);                       // now in EXECUTE
    rst_n = 1'b0;
    #1;
    check("abort_wb", {31'b0, wb_valid}, 32'd0);
    check("abort_ready", {31'b0, instr_ready}, 32'd0);
    check("abort_alu_a", {24'b0, alu_a}, 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("abort_wb_hold", {31'b0, wb_valid}, 32'd0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abort_wb_after", {31'b0, wb_valid}, 32'd0);
    end
    check("abort_idle", {31'b0, instr_ready}, 32'd1);
`ifdef ALU_SEQ_FLAGS_EN
    check("abort_flags", {30'b0, zero_flag, neg_flag}, 32'd0);
`endif
    $display("reset abort: wb_valid=%0b ready=%0b", wb_valid, instr_ready);
    // Registers read back as zero through the ALU operand path.
    run_vec(100, mk(enc(3'b000, 3, 0, 1), 0, 3'd0, 8'h00, 8'h00, 3, 8'h00, 1, 0));
    run_vec(101, mk(enc(3'b011, 3, 2, 3), 0, 3'd3, 8'h00, 8'h00, 3, 8'h00, 1, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle FSM stage directly upstream of the 8-bit combinational ALU.
- Accepts 16-bit instructions over a valid/ready handshake and reads operands from an internal 4x8 register file.
- Drives alu_control, alu_a and alu_b into the ALU, captures alu_result, and writes it back to the destination register.
- Sole producer of ALU stimulus and sole consumer of its result in the RISC_FSM datapath.

Parameters:
- DATA_W, 8, datapath width; must equal the ALU operand width.
- NUM_REGS, 4, register-file depth; register address width is log2(NUM_REGS) = 2.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- instr_valid  input  1  instruction word present on instr
- instr  input  16  instruction word
- instr_ready  output  1  sequencer can accept an instruction
- alu_control  output  3  ALU op select (000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT)
- alu_a  output  8  ALU operand A
- alu_b  output  8  ALU operand B
- alu_result  input  8  combinational result from ALU
- wb_valid  output  1  one-cycle pulse; write-back performed
- wb_addr  output  2  register written
- wb_data  output  8  value written
- illegal  output  1  one-cycle pulse on an undefined opcode

Behaviour:
- Reset (rst_n low, asynchronous): all of the following are cleared to 0: state=IDLE, registers R0-R3, instr_ready, alu_control, alu_a, alu_b, wb_valid, wb_addr, wb_data, illegal. The instruction latch is cleared too.
- Instruction format:
  - [15:13] opcode: 000-100 ALU op, 101 LDI, 110/111 illegal.
  - [12:11] rd.
  - [10:9] rs1, [8:7] rs2 (ALU ops).
  - [7:0] imm (LDI).
  - Unused bits are ignored.
- States: IDLE -> DECODE -> EXECUTE -> WRITEBACK -> IDLE.
- IDLE:
  - instr_ready=1.
  - instr_valid && instr_ready latches instr and moves to DECODE.
  - instr_ready is registered. It deasserts the cycle after acceptance and stays 0 until the FSM returns to IDLE.
- DECODE:
  - Opcode 110/111: pulse illegal, return to IDLE. No write-back, register file unchanged.
  - Otherwise register operands. ALU op: alu_a=R[rs1], alu_b=R[rs2]. NOT: alu_b=0. LDI: alu_control=000, alu_a=imm, alu_b=0.
  - Go to EXECUTE.
- EXECUTE: ALU inputs held stable for the whole cycle; alu_result sampled at the end of the cycle into the result register.
- WRITEBACK: R[rd] <= captured result; wb_valid=1, wb_addr=rd, wb_data=result for exactly this cycle; next state IDLE.
- alu_a, alu_b and alu_control hold their last values outside EXECUTE; they are not cleared.
- Latency: acceptance edge to wb_valid = 3 cycles. Throughput: one instruction per 4 cycles. Illegal instruction: illegal pulses 1 cycle after acceptance.
- Arithmetic is modulo 2^8: ADD/SUB wrap, no carry or borrow is kept.
- rd equal to rs1 or rs2: operands are read in DECODE, before write-back, so old values are used.
- instr_valid outside IDLE is ignored; the upstream holds the word until ready.
- rst_n asserted mid-instruction aborts it. No partial write-back occurs, and wb_valid must not glitch high.

Optional Feature:
- Macro: ALU_SEQ_FLAGS_EN.
- Defined:
  - Adds outputs zero_flag (1 bit) and neg_flag (1 bit).
  - Both update in WRITEBACK: zero_flag = (result==0), neg_flag = result[7].
  - Both hold until the next write-back; reset 0.
  - Illegal instructions leave both flags unchanged.
- Undefined: ports and flag logic absent; behaviour otherwise identical.

Decomposition:
- Package risc_pkg:
  - Opcode constants OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_LDI.
  - FSM state encoding ST_IDLE, ST_DECODE, ST_EXECUTE, ST_WRITEBACK.
  - Instruction field bit positions.
  - DATA_W default.
- Sub-module reg_file_4x8: two async read ports, one sync write port, async active-low reset to 0.

Test Plan:
- Reset, then LDI R1,0x05 and LDI R2,0x03 -> wb_valid 3 cycles after each acceptance; wb_data 0x05, then 0x03.
- ADD R3,R1,R2 -> alu_control=000, alu_a=0x05, alu_b=0x03 in EXECUTE; wb_addr=3, wb_data=0x08.
- LDI R0,0x00; SUB R0,R0,R1 (R1=0x05) -> wb_data=0xFB (wrap). With ALU_SEQ_FLAGS_EN: neg_flag=1, zero_flag=0.
- NOT R2,R2 with R2=0x0F -> alu_b=0x00, wb_data=0xF0. AND R3,R1,R1 with R1=0x05 -> wb_data=0x05.
- Instruction with opcode 110 -> illegal pulses 1 cycle after acceptance, no wb_valid, all registers unchanged, instr_ready back to 1 the next cycle.
- instr_valid held high continuously -> exactly one acceptance per 4 cycles. rst_n pulsed low during EXECUTE -> no wb_valid, R0-R3 read 0, FSM in IDLE.
